rca_4bit_df: RTL and testbench

- Parameterised ripple-carry adder, default 4 bits, built as a chain of 1-bit full adders (dataflow equations per bit).
- Computes a + b + cin, with sum and carry-out registered on the rising clock edge.
- Leaf arithmetic block used by datapath units that need a small, area-lean adder with one cycle of latency.

---
 rtl/rca_4bit_df.sv | 36 +++
 tb/tb_rca_4bit_df.sv | 109 ++++++++++
 2 files changed

// File: rtl/rca_4bit_df.sv
// rca_4bit_df: registered ripple-carry adder; define RCA_OVERFLOW_EN to add the signed overflow output ovf.
module rca_4bit_df #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end
  always_ff @(posedge clk) begin
    sum  <= rst ? '0 : s;
    cout <= rst ? 1'b0 : c[WIDTH];
  end
`ifdef RCA_OVERFLOW_EN
  always_ff @(posedge clk)
    ovf <= rst ? 1'b0 : c[WIDTH] ^ c[WIDTH-1];
`endif
endmodule

// File: tb/tb_rca_4bit_df.sv
// tb_rca_4bit_df: scoreboard bench for rca_4bit_df; ovf is checked when RCA_OVERFLOW_EN is defined.
module tb_rca_4bit_df;
  typedef struct {
    logic [4:0] exp;
    logic       eovf;
    string      name;
  } item_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       cin = 1'b0;
  logic [3:0] sum;
  logic       cout;
  logic       ovf_seen;
  item_t      q[$];
  int         checks = 0;
  int         errors = 0;
`ifdef RCA_OVERFLOW_EN
  logic ovf;
  assign ovf_seen = ovf;
  rca_4bit_df #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout), .ovf(ovf));
`else
  assign ovf_seen = 1'b0;
  rca_4bit_df #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout));
`endif
  always #5 clk = ~clk;
  function automatic logic sovf(input logic r, input logic [3:0] x, input logic [3:0] y, input logic ci);
    int sx, sy, t;
    sx = x[3] ? int'(x) - 16 : int'(x);
    sy = y[3] ? int'(y) - 16 : int'(y);
    t  = sx + sy + int'(ci);
    return !r && (t > 7 || t < -8);
  endfunction
  task automatic step(input logic r, input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                      input logic [4:0] exp, input string name);
    item_t it;
    @(negedge clk);
    rst = r; a = ta; b = tb; cin = tc;
    @(posedge clk);
    it.exp  = exp;
    it.eovf = sovf(r, ta, tb, tc);
    it.name = name;
    q.push_back(it);
  endtask
  task automatic step_ovf(input logic [3:0] ta, input logic [3:0] tb, input logic tc,
                          input logic [4:0] exp, input logic eo, input string name);
    item_t it;
    @(negedge clk);
    rst = 1'b0; a = ta; b = tb; cin = tc;
    @(posedge clk);
    it.exp  = exp;
    it.eovf = eo;
    it.name = name;
    q.push_back(it);
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t it;
      it = q.pop_front();
      checks++;
      if ({cout, sum} !== it.exp) begin
        errors++;
        $display("FAIL %s: got cout/sum %b/%h, expected %b/%h", it.name, cout, sum, it.exp[4], it.exp[3:0]);
      end
`ifdef RCA_OVERFLOW_EN
      checks++;
      if (ovf_seen !== it.eovf) begin
        errors++;
        $display("FAIL %s ovf: got %b, expected %b", it.name, ovf_seen, it.eovf);
      end
`endif
    end
  end
  initial begin
    step(1'b1, 4'hA, 4'h5, 1'b1, 5'h00, "reset0");
    step(1'b1, 4'hA, 4'h5, 1'b1, 5'h00, "reset1");
    step(1'b0, 4'h3, 4'h4, 1'b0, 5'h07, "add_3_4");
    step(1'b0, 4'h9, 4'h8, 1'b0, 5'h11, "add_9_8");
    step(1'b0, 4'hF, 4'h1, 1'b0, 5'h10, "wrap_f_1");
    step(1'b0, 4'hF, 4'h0, 1'b1, 5'h10, "cin_f_0");
    step(1'b0, 4'hF, 4'hF, 1'b1, 5'h1F, "max");
    for (int ci = 0; ci < 2; ci++)
      for (int v = 0; v < 256; v++) begin
        logic [3:0] va, vb;
        va = 4'(v >> 4);
        vb = 4'(v);
        step(1'b0, va, vb, 1'(ci), 5'(int'(va) + int'(vb) + ci), ci ? "sweep_cin1" : "sweep_cin0");
      end
    for (int k = 0; k < 4; k++)
      step(1'b0, 4'hF, 4'h0, 1'(k), k[0] ? 5'h10 : 5'h0F, "ripple");
    step(1'b0, 4'h7, 4'h7, 1'b0, 5'h0E, "stream0");
    step(1'b0, 4'h7, 4'h7, 1'b0, 5'h0E, "stream1");
    step(1'b1, 4'h7, 4'h7, 1'b0, 5'h00, "mid_reset");
    step(1'b0, 4'h7, 4'h7, 1'b0, 5'h0E, "after_reset");
    step_ovf(4'h7, 4'h1, 1'b0, 5'h08, 1'b1, "ovf_7_1");
    step_ovf(4'h8, 4'h8, 1'b0, 5'h10, 1'b1, "ovf_8_8");
    step_ovf(4'h3, 4'h2, 1'b0, 5'h05, 1'b0, "ovf_3_2");
    step_ovf(4'hF, 4'hF, 1'b1, 5'h1F, 1'b0, "ovf_neg1_neg1_c");
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
